instr_encoder_loader: RTL and testbench

- Inverse of the instruction decoder: packs instruction fields into the 16-bit CPU instruction word and writes them sequentially into instruction memory.
- Fields enter over a valid/ready handshake and are buffered in a small FIFO.
- The FIFO drains one word per cycle into the imem write port, with an auto-incrementing address.
- Used by the program loader / testbench front-end to fill imem before the CPU runs.

---
 rtl/instr_encoder_loader_if.sv | 33 +++
 rtl/instr_encoder_loader.sv | 93 +++++++++
 tb/tb_instr_encoder_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Handshake bundle between the program-loader front end, the encoder and imem.
// The master side supplies instruction fields and the imem ready flag; the
// slave side (the encoder) returns in_ready and drives the imem write port.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    // Field-set handshake from the loader front end.
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [1:0]        write_addr;
    logic [1:0]        read_addr2;
    logic              immediate_select;
    logic [7:0]        immediate;

    // Instruction memory write port.
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              imem_ready;

    modport master (
        output in_valid, alu_op, write_addr, read_addr2, immediate_select,
               immediate, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, alu_op, write_addr, read_addr2, immediate_select,
               immediate, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into the 16-bit CPU instruction word, buffers them
// in a small FIFO and streams them into imem at consecutive addresses starting
// from 0. Once every imem location has been written, the write port stops
// until start or reset.
module instr_encoder_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]       words_written,
    output logic                  mem_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fifo_count;
    logic [ADDR_W-1:0] wr_addr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [15:0]       enc_word;

    // Canonical encoding: the immediate byte is forced to zero in register form.
    assign enc_word = {bus.alu_op, bus.write_addr, bus.read_addr2, bus.immediate_select,
                       bus.immediate_select ? bus.immediate : 8'h00};

    // FIFO_DEPTH is a power of two, so the count's MSB alone marks "full".
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = fifo_count[PTR_W];

    // in_ready deliberately ignores a same-cycle pop: a full FIFO refuses a push.
    assign bus.in_ready   = rst_n && !fifo_full && !mem_full && !start;
    assign bus.imem_we    = !fifo_empty && !mem_full;
    assign bus.imem_wdata = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
    assign bus.imem_addr  = wr_addr;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.imem_we && bus.imem_ready;

    // Capture the encoded word into the FIFO slot at the write pointer.
    // NOTE: the storage array has no reset; fifo_count alone says which
    // entries are valid, and imem_wdata is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    // Pointer, occupancy, address and fill tracking; start outranks push/pop.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            wr_addr       <= '0;
            words_written <= '0;
            mem_full      <= 1'b0;
        end else if (start) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            wr_addr       <= '0;
            words_written <= '0;
            mem_full      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                wr_addr       <= wr_addr + ADDR_W'(1);
                words_written <= words_written + (ADDR_W + 1)'(1);
                // The address tracks words_written, so committing the top
                // location is the commit that fills imem; the address wraps to 0.
                if (&wr_addr) begin
                    mem_full <= 1'b1;
                end
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - (PTR_W + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader. A main instance (ADDR_W=8)
// is tracked by a queue-based reference model; a second instance (ADDR_W=3)
// exercises the imem-full boundary against a hand-derived timeline.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int AWS   = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start   = 1'b0;
    logic start_s = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(AW))  bus ();
    instr_encoder_loader_if #(.ADDR_W(AWS)) sbus ();

    logic [AW:0]  words_written;
    logic         mem_full;
    logic [AWS:0] words_written_s;
    logic         mem_full_s;

    instr_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .words_written(words_written), .mem_full(mem_full)
    );

    instr_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bus(sbus),
        .words_written(words_written_s), .mem_full(mem_full_s)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is a queue of encoded words, imem progress is
    // plain integers.
    logic [15:0] m_q[$];
    int          m_addr;
    int          m_written;
    bit          m_full;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] wa,
                                        input logic [1:0] ra, input logic isel,
                                        input logic [7:0] imm);
        logic [7:0] imm_field;
        imm_field = isel ? imm : 8'h00;
        return {op, wa, ra, isel, imm_field};
    endfunction

    function automatic logic exp_we();
        return (m_q.size() > 0) && !m_full;
    endfunction

    function automatic logic [15:0] exp_wdata();
        return (m_q.size() > 0) ? m_q[0] : 16'h0000;
    endfunction

    function automatic logic exp_ready();
        return (m_q.size() < DEPTH) && !m_full && !start;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_addr    = 0;
        m_written = 0;
        m_full    = 0;
    endtask

    // Advance the model by one clock edge using the inputs as currently driven,
    // then let the edge happen and settle 1 time unit past it.
    task automatic step();
        bit          acc;
        bit          com;
        logic [15:0] w;
        acc = bus.in_valid && (m_q.size() < DEPTH) && !m_full && !start;
        com = (m_q.size() > 0) && !m_full && bus.imem_ready;
        w   = enc(bus.alu_op, bus.write_addr, bus.read_addr2, bus.immediate_select, bus.immediate);
        if (start) begin
            model_clear();
        end else begin
            if (com) begin
                void'(m_q.pop_front());
                m_addr = (m_addr + 1) % (1 << AW);
                m_written++;
                if (m_written == (1 << AW)) m_full = 1;
            end
            if (acc) m_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        bus.alu_op           = 3'($urandom);
        bus.write_addr       = 2'($urandom);
        bus.read_addr2       = 2'($urandom);
        bus.immediate_select = 1'($urandom);
        bus.immediate        = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL start_blocks_ready: got %0b want 0", bus.in_ready); end
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.imem_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.imem_ready = 1'b0;
        rand_fields();
        sbus.alu_op = '0; sbus.write_addr = '0; sbus.read_addr2 = '0;
        sbus.immediate_select = 1'b0; sbus.immediate = '0;
        #3;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b want 0", bus.imem_we); end
        checks++; if (bus.imem_wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata: got %h want 0000", bus.imem_wdata); end
        checks++; if (bus.imem_addr !== 8'h0) begin failures++; $display("FAIL reset_addr: got %h want 00", bus.imem_addr); end
        checks++; if (words_written !== 9'd0) begin failures++; $display("FAIL reset_words: got %0d want 0", words_written); end
        checks++; if (mem_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %0b want 0", mem_full); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reg_encoding();
        bus.alu_op = 3'b010; bus.write_addr = 2'b01; bus.read_addr2 = 2'b11;
        bus.immediate_select = 1'b0; bus.immediate = 8'hAB;
        bus.in_valid = 1'b1; bus.imem_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reg_in_ready: got %0b want 1", bus.in_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL reg_latency_we: got %0b want 0", bus.imem_we); end
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL reg_we: got %0b want 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reg_addr: got %h want 00", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== 16'h4E00) begin failures++; $display("FAIL reg_wdata: got %h want 4e00", bus.imem_wdata); end
        step();
        #1;
        checks++; if (words_written !== 9'd1) begin failures++; $display("FAIL reg_words: got %0d want 1", words_written); end
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL reg_we_after: got %0b want 0", bus.imem_we); end
    endtask

    task automatic test_imm_encoding();
        bus.alu_op = 3'b111; bus.write_addr = 2'b10; bus.read_addr2 = 2'b00;
        bus.immediate_select = 1'b1; bus.immediate = 8'h5A;
        bus.in_valid = 1'b1;
        #1;
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.imem_wdata !== 16'hF15A) begin failures++; $display("FAIL imm_wdata: got %h want f15a", bus.imem_wdata); end
        checks++; if (bus.imem_addr !== 8'h01) begin failures++; $display("FAIL imm_addr: got %h want 01", bus.imem_addr); end
        step();
        #1;
        checks++; if (words_written !== 9'd2) begin failures++; $display("FAIL imm_words: got %0d want 2", words_written); end
    endtask

    task automatic test_backpressure();
        logic [15:0] held[$];
        pulse_start();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.in_ready !== (i < 4)) begin failures++; $display("FAIL bp_accept%0d: got %0b want %0b", i, bus.in_ready, (i < 4)); end
            step();
        end
        bus.in_valid = 1'b0;
        held = m_q;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL bp_stall_we: got %0b want 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL bp_stall_addr: got %h want 00", bus.imem_addr); end
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL bp_drain_we%0d: got %0b want 1", i, bus.imem_we); end
            checks++; if (bus.imem_addr !== 8'(i)) begin failures++; $display("FAIL bp_drain_addr%0d: got %h want %h", i, bus.imem_addr, 8'(i)); end
            checks++; if (bus.imem_wdata !== held[i]) begin failures++; $display("FAIL bp_drain_data%0d: got %h want %h", i, bus.imem_wdata, held[i]); end
            checks++; if (bus.in_ready !== (i > 0)) begin failures++; $display("FAIL bp_ready%0d: got %0b want %0b", i, bus.in_ready, (i > 0)); end
            step();
        end
        #1;
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL bp_done_we: got %0b want 0", bus.imem_we); end
        checks++; if (words_written !== 9'd4) begin failures++; $display("FAIL bp_words: got %0d want 4", words_written); end
    endtask

    task automatic test_stream();
        pulse_start();
        bus.imem_ready = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            rand_fields();
            bus.in_valid = (cyc < 10);
            #1;
            checks++; if (bus.imem_we !== (cyc >= 1)) begin failures++; $display("FAIL stream_we%0d: got %0b want %0b", cyc, bus.imem_we, (cyc >= 1)); end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d: got %0b want 1", cyc, bus.in_ready); end
            if (cyc >= 1) begin
                checks++; if (bus.imem_addr !== 8'(cyc - 1)) begin failures++; $display("FAIL stream_addr%0d: got %h want %h", cyc, bus.imem_addr, 8'(cyc - 1)); end
                checks++; if (bus.imem_wdata !== exp_wdata()) begin failures++; $display("FAIL stream_data%0d: got %h want %h", cyc, bus.imem_wdata, exp_wdata()); end
            end
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (words_written !== 9'd10) begin failures++; $display("FAIL stream_words: got %0d want 10", words_written); end
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL stream_idle_we: got %0b want 0", bus.imem_we); end
    endtask

    // Small instance: 8 imem locations, 9 words offered at one per cycle with
    // imem always ready. Word c is accepted at edge c and written in cycle c+1;
    // the 8th commit sets mem_full, so word 8 is accepted but never written.
    task automatic test_fill();
        logic [15:0] words[9];
        logic [15:0] w;
        bus.in_valid = 1'b0; bus.imem_ready = 1'b0;
        sbus.imem_ready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            sbus.alu_op = 3'($urandom); sbus.write_addr = 2'($urandom);
            sbus.read_addr2 = 2'($urandom); sbus.immediate_select = 1'($urandom);
            sbus.immediate = 8'($urandom);
            if (c < 9) words[c] = enc(sbus.alu_op, sbus.write_addr, sbus.read_addr2, sbus.immediate_select, sbus.immediate);
            sbus.in_valid = (c < 9);
            #1;
            checks++; if (sbus.in_ready !== (c <= 8)) begin failures++; $display("FAIL fill_ready%0d: got %0b want %0b", c, sbus.in_ready, (c <= 8)); end
            checks++; if (sbus.imem_we !== (c >= 1 && c <= 8)) begin failures++; $display("FAIL fill_we%0d: got %0b want %0b", c, sbus.imem_we, (c >= 1 && c <= 8)); end
            if (c >= 1 && c <= 8) begin
                checks++; if (sbus.imem_addr !== 3'(c - 1)) begin failures++; $display("FAIL fill_addr%0d: got %0d want %0d", c, sbus.imem_addr, c - 1); end
                checks++; if (sbus.imem_wdata !== words[c-1]) begin failures++; $display("FAIL fill_data%0d: got %h want %h", c, sbus.imem_wdata, words[c-1]); end
            end
            checks++; if (mem_full_s !== (c == 9)) begin failures++; $display("FAIL fill_full%0d: got %0b want %0b", c, mem_full_s, (c == 9)); end
            @(posedge clk);
            #1;
        end
        sbus.in_valid = 1'b0;
        #1;
        checks++; if (words_written_s !== 4'd8) begin failures++; $display("FAIL fill_words: got %0d want 8", words_written_s); end
        checks++; if (sbus.imem_addr !== 3'd0) begin failures++; $display("FAIL fill_wrap_addr: got %0d want 0", sbus.imem_addr); end
        checks++; if (sbus.imem_we !== 1'b0) begin failures++; $display("FAIL fill_hold_we: got %0b want 0", sbus.imem_we); end
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        #1;
        checks++; if (mem_full_s !== 1'b0) begin failures++; $display("FAIL fill_restart_full: got %0b want 0", mem_full_s); end
        checks++; if (words_written_s !== 4'd0) begin failures++; $display("FAIL fill_restart_words: got %0d want 0", words_written_s); end
        checks++; if (sbus.imem_we !== 1'b0) begin failures++; $display("FAIL fill_restart_we: got %0b want 0", sbus.imem_we); end
        sbus.alu_op = 3'b101; sbus.write_addr = 2'b11; sbus.read_addr2 = 2'b01;
        sbus.immediate_select = 1'b1; sbus.immediate = 8'h3C;
        w = enc(3'b101, 2'b11, 2'b01, 1'b1, 8'h3C);
        sbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        #1;
        checks++; if (sbus.imem_we !== 1'b1) begin failures++; $display("FAIL fill_next_we: got %0b want 1", sbus.imem_we); end
        checks++; if (sbus.imem_addr !== 3'd0) begin failures++; $display("FAIL fill_next_addr: got %0d want 0", sbus.imem_addr); end
        checks++; if (sbus.imem_wdata !== w) begin failures++; $display("FAIL fill_next_data: got %h want %h", sbus.imem_wdata, w); end
        @(posedge clk);
        #1;
        sbus.imem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            bus.in_valid   = 1'b1;
            bus.imem_ready = (i < 2);
            #1;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (words_written !== 9'(m_written)) begin failures++; $display("FAIL mid_pre_words: got %0d want %0d", words_written, m_written); end
        checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL mid_pre_we: got %0b want 1", bus.imem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we: got %0b want 0", bus.imem_we); end
        checks++; if (words_written !== 9'd0) begin failures++; $display("FAIL mid_rst_words: got %0d want 0", words_written); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL mid_rst_addr: got %h want 00", bus.imem_addr); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %0b want 0", bus.in_ready); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Same scenario, abandoned with start instead of reset.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            bus.in_valid = 1'b1;
            #1;
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL mid_start_pre_we: got %0b want 1", bus.imem_we); end
        bus.imem_ready = 1'b1;
        pulse_start();
        #1;
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL mid_start_we: got %0b want 0", bus.imem_we); end
        checks++; if (words_written !== 9'd0) begin failures++; $display("FAIL mid_start_words: got %0d want 0", words_written); end
        rand_fields();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.imem_we !== 1'b1) begin failures++; $display("FAIL mid_next_we: got %0b want 1", bus.imem_we); end
        checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL mid_next_addr: got %h want 00", bus.imem_addr); end
        checks++; if (bus.imem_wdata !== exp_wdata()) begin failures++; $display("FAIL mid_next_data: got %h want %h", bus.imem_wdata, exp_wdata()); end
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 300; cyc++) begin
            rand_fields();
            start          = ($urandom_range(0, 31) == 0);
            bus.in_valid   = 1'($urandom);
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (bus.in_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready%0d: got %0b want %0b", cyc, bus.in_ready, exp_ready()); end
            checks++; if (bus.imem_we !== exp_we()) begin failures++; $display("FAIL rnd_we%0d: got %0b want %0b", cyc, bus.imem_we, exp_we()); end
            checks++; if (bus.imem_addr !== 8'(m_addr)) begin failures++; $display("FAIL rnd_addr%0d: got %h want %h", cyc, bus.imem_addr, 8'(m_addr)); end
            checks++; if (bus.imem_wdata !== exp_wdata()) begin failures++; $display("FAIL rnd_data%0d: got %h want %h", cyc, bus.imem_wdata, exp_wdata()); end
            checks++; if (words_written !== 9'(m_written)) begin failures++; $display("FAIL rnd_words%0d: got %0d want %0d", cyc, words_written, m_written); end
            checks++; if (mem_full !== m_full) begin failures++; $display("FAIL rnd_full%0d: got %0b want %0b", cyc, mem_full, m_full); end
            step();
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reg_encoding();
        test_imm_encoding();
        test_backpressure();
        test_stream();
        test_fill();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
